// File: rtl/cnn_pkg.sv
// Shared CNN-stage definitions: default feature-map dimensions, the pooling
// FSM state encoding, and the sub-word packing order of 32-bit result words.
package cnn_pkg;

  localparam int unsigned DEF_IN_W   = 32;
  localparam int unsigned DEF_IN_H   = 32;
  localparam int unsigned DEF_NUM_CH = 32;
  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned WORD_W     = 32;

  // Slot 0 of a packed word sits in the most significant bits.
  localparam bit SLOT0_AT_MSB = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACCUM,
    STORE,
    DONE_ST
  } pool_state_e;

  // Bit offset of the least significant bit of sub-word 'slot' in a packed word.
  function automatic int unsigned slot_lsb(input int unsigned slot,
                                           input int unsigned data_w);
    if (SLOT0_AT_MSB) return WORD_W - (slot + 1) * data_w;
    else              return slot * data_w;
  endfunction

endpackage

// File: rtl/maxpool2x2_4b_32ch_if.sv
// Bus bundle for the 2x2 max-pool stage.
//   start/busy/done      : pass control handshake
//   src_addr/src_data    : read port toward the upstream conv buffer
//   read_addr/read_data  : read port into the pooled result buffer
// master = environment side, slave = pooling engine side.
interface maxpool2x2_4b_32ch_if #(
  parameter int unsigned DATA_W = 4
);
  logic              start;
  logic              busy;
  logic              done;
  logic [31:0]       src_addr;
  logic [DATA_W-1:0] src_data;
  logic [31:0]       read_addr;
  logic [DATA_W-1:0] read_data;

  modport master (
    output start, src_data, read_addr,
    input  busy, done, src_addr, read_data
  );

  modport slave (
    input  start, src_data, read_addr,
    output busy, done, src_addr, read_data
  );
endinterface

// File: rtl/pooled_buf_1w1r.sv
// Packed pooled-result buffer: one write port, one independent registered
// read port, 32-bit words. Storage has no reset so it maps onto block RAM.
//   clk, reset : clock, async active-high reset (read register only)
//   we/waddr/wdata : write port
//   raddr/rdata    : read port, one-cycle latency
module pooled_buf_1w1r
  import cnn_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/maxpool2x2_4b_32ch.sv
// 2x2 stride-2 unsigned max pooling over a multi-channel feature map read
// one sub-word at a time from the upstream conv buffer. Results are packed
// eight per 32-bit word into an internal buffer with its own read port.
//   clk, reset : clock, async active-high reset
//   bus.start  : pulse that begins a pass (ignored while busy)
//   bus.busy   : high for the duration of a pass
//   bus.done   : one-cycle pulse at pass completion
//   bus.src_addr / bus.src_data : upstream read, data one cycle after address
//   bus.read_addr / bus.read_data : result read, one-cycle latency
module maxpool2x2_4b_32ch
  import cnn_pkg::*;
#(
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned IN_H   = DEF_IN_H,
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input logic                  clk,
  input logic                  reset,
  maxpool2x2_4b_32ch_if.slave  bus
);

  localparam int unsigned OUT_W    = IN_W / 2;
  localparam int unsigned OUT_H    = IN_H / 2;
  localparam int unsigned N_OUT    = NUM_CH * OUT_W * OUT_H;
  localparam int unsigned PER_WORD = WORD_W / DATA_W;
  localparam int unsigned SEL_W    = (PER_WORD > 1) ? $clog2(PER_WORD) : 1;
  localparam int unsigned DEPTH    = N_OUT / PER_WORD;
  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW       = AW + SEL_W;
  localparam int unsigned CW       = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned RW       = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned HW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  pool_state_e       state;
  logic [HW-1:0]     ch;
  logic [RW-1:0]     r;
  logic [CW-1:0]     c;
  logic [1:0]        tap;
  logic [NW-1:0]     n;
  logic [DATA_W-1:0] run_max;
  logic [WORD_W-1:0] pack;
  logic [SEL_W-1:0]  sel_q;
  logic [WORD_W-1:0] rd_word;

  logic              c_last_c, r_last_c, ch_last_c, pass_last_c;
  logic [CW-1:0]     nc_c;
  logic [RW-1:0]     nr_c;
  logic [HW-1:0]     nch_c;
  logic              wr_en_c;
  logic [AW-1:0]     wr_addr_c;
  logic [WORD_W-1:0] wr_data_c;
  logic              unused_read_hi;

  // Upstream address of a window tap; tap[1] selects the row, tap[0] the column.
  function automatic logic [31:0] addr_of(input logic [HW-1:0] a_ch,
                                          input logic [RW-1:0] a_r,
                                          input logic [CW-1:0] a_c,
                                          input logic [1:0]    a_tap);
    logic [31:0] y;
    logic [31:0] x;
    y = 32'(a_r) * 32'd2 + 32'(a_tap[1]);
    x = 32'(a_c) * 32'd2 + 32'(a_tap[0]);
    return 32'(a_ch) * 32'(IN_W * IN_H) + y * 32'(IN_W) + x;
  endfunction

  // Next output coordinate, column fastest, then row, then channel.
  always_comb begin
    c_last_c    = (c == CW'(OUT_W - 1));
    r_last_c    = (r == RW'(OUT_H - 1));
    ch_last_c   = (ch == HW'(NUM_CH - 1));
    pass_last_c = c_last_c & r_last_c & ch_last_c;
    nc_c        = c_last_c ? '0 : c + 1'b1;
    nr_c        = r;
    nch_c       = ch;
    if (c_last_c) begin
      nr_c = r_last_c ? '0 : r + 1'b1;
      if (r_last_c) nch_c = ch + 1'b1;
    end
  end

  // Merge the finished window into its slot; commit the word on its last slot.
  always_comb begin
    wr_data_c = pack;
    wr_data_c[slot_lsb(32'(n[SEL_W-1:0]), DATA_W) +: DATA_W] = run_max;
    wr_en_c   = (state == STORE) && (n[SEL_W-1:0] == SEL_W'(PER_WORD - 1));
    wr_addr_c = n[NW-1:SEL_W];
  end

  // Pass sequencer. src_addr is loaded on every entry to ISSUE so it is
  // presented during ISSUE and held through WAIT and ACCUM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.src_addr <= '0;
      ch           <= '0;
      r            <= '0;
      c            <= '0;
      tap          <= '0;
      n            <= '0;
      run_max      <= '0;
      pack         <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= ISSUE;
            bus.busy     <= 1'b1;
            bus.src_addr <= '0;
            ch           <= '0;
            r            <= '0;
            c            <= '0;
            tap          <= '0;
            n            <= '0;
          end
        end
        ISSUE: state <= WAIT;
        WAIT:  state <= ACCUM;
        ACCUM: begin
          // First tap replaces the running max, which equals max(0, tap).
          if ((tap == 2'd0) || (bus.src_data > run_max)) run_max <= bus.src_data;
          tap <= tap + 2'd1;
          if (tap == 2'd3) begin
            state <= STORE;
          end else begin
            state        <= ISSUE;
            bus.src_addr <= addr_of(ch, r, c, tap + 2'd1);
          end
        end
        STORE: begin
          pack <= wr_data_c;
          n    <= n + 1'b1;
          c    <= nc_c;
          r    <= nr_c;
          ch   <= nch_c;
          if (pass_last_c) begin
            state <= DONE_ST;
          end else begin
            state        <= ISSUE;
            bus.src_addr <= addr_of(nch_c, nr_c, nc_c, 2'd0);
          end
        end
        DONE_ST: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  pooled_buf_1w1r #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en_c),
    .waddr (wr_addr_c),
    .wdata (wr_data_c),
    .raddr (bus.read_addr[SEL_W +: AW]),
    .rdata (rd_word)
  );

  // Slot select follows the word read by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_q <= '0;
    else       sel_q <= bus.read_addr[SEL_W-1:0];
  end

  always_comb begin
    bus.read_data = rd_word[slot_lsb(32'(sel_q), DATA_W) +: DATA_W];
  end

  assign unused_read_hi = ^bus.read_addr[31:NW];

endmodule

// File: tb/tb_maxpool2x2_4b_32ch.sv
// Directed bench for maxpool2x2_4b_32ch on a reduced 32x12x6 map
// (576 outputs, 72 words, 576*13+2 = 7490 cycles per pass).
module tb_maxpool2x2_4b_32ch;

  localparam int IN_W     = 32;
  localparam int IN_H     = 12;
  localparam int NUM_CH   = 6;
  localparam int N_OUT    = NUM_CH * (IN_W / 2) * (IN_H / 2);
  localparam int IMG_SZ   = NUM_CH * IN_W * IN_H;
  localparam int PASS_CYC = N_OUT * 13 + 2;
  localparam int TIMEOUT  = PASS_CYC + 500;

  localparam int M_CONST  = 0;
  localparam int M_HOT    = 1;
  localparam int M_WINDOW = 2;
  localparam int M_RAMP   = 3;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   failures = 0;

  maxpool2x2_4b_32ch_if #(.DATA_W(4)) bus ();

  maxpool2x2_4b_32ch #(
    .IN_W   (IN_W),
    .IN_H   (IN_H),
    .NUM_CH (NUM_CH),
    .DATA_W (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Upstream conv buffer: data follows the address by one cycle.
  logic [3:0] img [IMG_SZ];
  always @(posedge clk) bus.src_data <= img[bus.src_addr[11:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx(input int ch, input int y, input int x);
    return ch * IN_W * IN_H + y * IN_W + x;
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < IMG_SZ; i++) img[i] = (mode == M_CONST) ? 4'd3 : 4'd0;
    if (mode == M_HOT) img[idx(5, 10, 21)] = 4'd6;
    if (mode == M_WINDOW) begin
      img[idx(0,0,0)] = 4'd1;  img[idx(0,0,1)] = 4'd6;  img[idx(0,1,0)] = 4'd2;  img[idx(0,1,1)] = 4'd0;
      img[idx(0,0,2)] = 4'd7;  img[idx(0,0,3)] = 4'd1;  img[idx(0,1,2)] = 4'd1;  img[idx(0,1,3)] = 4'd1;
      img[idx(0,0,4)] = 4'd9;  img[idx(0,0,5)] = 4'd15; img[idx(0,1,4)] = 4'd12; img[idx(0,1,5)] = 4'd8;
      img[idx(0,0,6)] = 4'd8;  img[idx(0,0,7)] = 4'd0;  img[idx(0,1,6)] = 4'd0;  img[idx(0,1,7)] = 4'd14;
      img[idx(5,10,30)] = 4'd10; img[idx(5,10,31)] = 4'd10;
      img[idx(5,11,30)] = 4'd10; img[idx(5,11,31)] = 4'd10;
    end
    if (mode == M_RAMP)
      for (int ch = 0; ch < NUM_CH; ch++)
        for (int y = 0; y < IN_H; y++)
          for (int x = 0; x < IN_W; x++)
            img[idx(ch, y, x)] = 4'((x >> 1) % 7);
  endtask

  // Hand-derived pooled value at output nibble index n for each image.
  function automatic logic [3:0] exp_out(input int mode, input int n);
    case (mode)
      M_CONST:  return 4'd3;
      M_HOT:    return (n == 570) ? 4'd6 : 4'd0;
      M_WINDOW: begin
        case (n)
          0:       return 4'd6;
          1:       return 4'd7;
          2:       return 4'd15;
          3:       return 4'd14;
          575:     return 4'd10;
          default: return 4'd0;
        endcase
      end
      default:  return 4'((n % 16) % 7);
    endcase
  endfunction

  task automatic read_nib(input int addr, output logic [3:0] v);
    @(negedge clk);
    bus.read_addr = 32'(addr);
    @(posedge clk);
    #1;
    v = bus.read_data;
  endtask

  task automatic verify_all(input int mode, input string tag);
    logic [3:0] v;
    for (int n = 0; n < N_OUT; n++) begin
      read_nib(n, v);
      check($sformatf("%s[%0d]", tag, n), 32'(v), 32'(exp_out(mode, n)));
    end
  endtask

  task automatic launch();
    @(negedge clk);
    bus.start = 1'b1;
  endtask

  // start is high on entry (cycle 0). Optionally pulses start again at
  // cycle extra_at; with chain set, raises start in the done cycle.
  task automatic run_pass(input int extra_at, input bit chain, output int lat, output int pulses);
    int cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 1;
    lat = -1;
    pulses = 0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    while (lat < 0 && cyc < TIMEOUT) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.start = (cyc == extra_at);
      if (bus.done) begin
        lat = cyc;
        pulses++;
        check("busy_low_at_done", 32'(bus.busy), 32'd0);
      end
    end
    if (lat >= 0 && chain) begin
      bus.start = 1'b1;
    end else begin
      bus.start = 1'b0;
      repeat (20) begin
        @(posedge clk);
        #1;
        if (bus.done) pulses++;
      end
    end
  endtask

  initial begin
    int         lat;
    int         pulses;
    int         cyc;
    logic [3:0] v;
    logic [31:0] word;

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.read_addr = '0;
    fill(M_CONST);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_src_addr", bus.src_addr, 32'd0);
    check("rst_read_data", 32'(bus.read_data), 32'd0);

    // Constant image with a second start at cycle 100 that must be ignored
    launch();
    run_pass(100, 1'b0, lat, pulses);
    check("const_latency", 32'(lat), 32'(PASS_CYC));
    check("const_done_pulses", 32'(pulses), 32'd1);
    verify_all(M_CONST, "const");

    // Single hot pixel
    fill(M_HOT);
    launch();
    run_pass(0, 1'b0, lat, pulses);
    check("hot_latency", 32'(lat), 32'(PASS_CYC));
    verify_all(M_HOT, "hot");

    // Window tap order and full-range values, then a start coincident with done
    fill(M_WINDOW);
    launch();
    run_pass(0, 1'b1, lat, pulses);
    check("win_latency", 32'(lat), 32'(PASS_CYC));
    run_pass(0, 1'b0, lat, pulses);
    check("chained_latency", 32'(lat), 32'(PASS_CYC));
    check("chained_pulses", 32'(pulses), 32'd1);
    verify_all(M_WINDOW, "win");

    // Reads during a pass see prior results; reset at cycle 5000 aborts
    fill(M_RAMP);
    launch();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 5000) begin
      if (cyc == 9) bus.read_addr = 32'd0;
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 10) begin
        check("read_prior_during_pass", 32'(bus.read_data), 32'd6);
        check("busy_mid_pass", 32'(bus.busy), 32'd1);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_src_addr", bus.src_addr, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Fresh pass after abort with the ramp image, checking packing order
    launch();
    run_pass(0, 1'b0, lat, pulses);
    check("ramp_latency", 32'(lat), 32'(PASS_CYC));
    check("ramp_pulses", 32'(pulses), 32'd1);
    word = '0;
    for (int i = 0; i < 8; i++) begin
      read_nib(i, v);
      word = {word[27:0], v};
    end
    check("ramp_word0", word, 32'h0123_4560);
    read_nib(7, v);
    check("ramp_addr7", 32'(v), 32'd0);
    verify_all(M_RAMP, "ramp");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
